// File: rtl/mig_app_arbiter.sv
// Round-robin arbiter sharing the MIG 7-series app_* user interface between a
// sample-write requester (r0) and a playback-read requester (r1), with read-data routing.
module mig_app_arbiter #(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 256,
    parameter int TAG_DEPTH = 16
) (
    input  logic              ui_clk,
    input  logic              sys_rst,
    input  logic              init_calib_complete,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rd_data,
    output logic              r0_rd_valid,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rd_data,
    output logic              r1_rd_valid,

    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,

    output logic              err_unexpected_rd
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0]       CMD_WRITE = 3'b000;
    localparam logic [2:0]       CMD_READ  = 3'b001;
    localparam logic [CNT_W-1:0] TAG_FULL  = CNT_W'(TAG_DEPTH);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t state, state_n;

    // Command register next-state values
    logic              rr_ptr, rr_ptr_n;
    logic              owner, owner_n;
    logic [ADDR_W-1:0] addr_n;
    logic [2:0]        cmd_n;
    logic              en_n;
    logic [DATA_W-1:0] wdata_n;
    logic              wren_n;
    logic [1:0]        ack_n;

    logic [1:0] eligible;
    logic       pick;
    logic       accept;
    logic       tags_full;
    logic       tag_push;
    logic       tag_pop;

    // Requester-ID FIFO: one bit per outstanding read, in MIG issue order
    logic             tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tag_count;

    assign tags_full   = (tag_count == TAG_FULL);
    assign eligible[0] = r0_req & (r0_we | ~tags_full);
    assign eligible[1] = r1_req & (r1_we | ~tags_full);
    assign pick        = (&eligible) ? rr_ptr : eligible[1];

    assign accept   = (state == ST_ISSUE) & app_en & app_rdy
                    & ((app_cmd == CMD_READ) | app_wdf_rdy);
    assign tag_push = accept & (app_cmd == CMD_READ);
    assign tag_pop  = app_rd_data_valid & (tag_count != '0);

    assign app_wdf_end = app_wdf_wren;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        owner_n  = owner;
        addr_n   = app_addr;
        cmd_n    = app_cmd;
        en_n     = app_en;
        wdata_n  = app_wdf_data;
        wren_n   = app_wdf_wren;
        ack_n    = 2'b00;

        case (state)
            ST_INIT: begin
                if (init_calib_complete) state_n = ST_IDLE;
            end

            ST_IDLE: begin
                if (!init_calib_complete) begin
                    state_n = ST_INIT;
                end else if (|eligible) begin
                    owner_n  = pick;
                    rr_ptr_n = ~pick;
                    en_n     = 1'b1;
                    state_n  = ST_ISSUE;
                    if (pick) begin
                        addr_n  = r1_addr;
                        cmd_n   = r1_we ? CMD_WRITE : CMD_READ;
                        wdata_n = r1_wdata;
                        wren_n  = r1_we;
                    end else begin
                        addr_n  = r0_addr;
                        cmd_n   = r0_we ? CMD_WRITE : CMD_READ;
                        wdata_n = r0_wdata;
                        wren_n  = r0_we;
                    end
                end
            end

            ST_ISSUE: begin
                // Calibration loss is ignored here; the latched command finishes first
                if (accept) begin
                    en_n         = 1'b0;
                    wren_n       = 1'b0;
                    ack_n[owner] = 1'b1;
                    state_n      = ST_IDLE;
                end
            end

            default: state_n = ST_INIT;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge ui_clk) begin
        if (!sys_rst) begin
            state        <= ST_INIT;
            rr_ptr       <= 1'b0;
            owner        <= 1'b0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_wren <= 1'b0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
        end else begin
            state        <= state_n;
            rr_ptr       <= rr_ptr_n;
            owner        <= owner_n;
            app_addr     <= addr_n;
            app_cmd      <= cmd_n;
            app_en       <= en_n;
            app_wdf_data <= wdata_n;
            app_wdf_wren <= wren_n;
            r0_ack       <= ack_n[0];
            r1_ack       <= ack_n[1];
        end
    end

    always_ff @(posedge ui_clk) begin
        if (!sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_count <= '0;
        end else begin
            if (tag_push) wr_ptr <= wr_ptr + 1'b1;
            if (tag_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
        end
    end

    // NOTE: the tag storage needs no reset; entries are only read once the count covers them.
    always_ff @(posedge ui_clk) begin
        if (tag_push) tag_mem[wr_ptr] <= owner;
    end

    always_ff @(posedge ui_clk) begin
        if (!sys_rst) begin
            r0_rd_data        <= '0;
            r1_rd_data        <= '0;
            r0_rd_valid       <= 1'b0;
            r1_rd_valid       <= 1'b0;
            err_unexpected_rd <= 1'b0;
        end else begin
            r0_rd_valid <= 1'b0;
            r1_rd_valid <= 1'b0;
            if (app_rd_data_valid) begin
                if (tag_count != '0) begin
                    if (tag_mem[rd_ptr]) begin
                        r1_rd_data  <= app_rd_data;
                        r1_rd_valid <= 1'b1;
                    end else begin
                        r0_rd_data  <= app_rd_data;
                        r0_rd_valid <= 1'b1;
                    end
                end else begin
                    // Data with nothing outstanding is dropped; the flag stays set until reset
                    err_unexpected_rd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Self-checking bench for mig_app_arbiter: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, and a randomized traffic phase.
module tb_mig_app_arbiter;

    localparam int ADDR_W    = 29;
    localparam int DATA_W    = 256;
    localparam int TAG_DEPTH = 16;

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct {
        int                id;
        bit                we;
        logic [ADDR_W-1:0] addr;
        int                cyc;
    } ack_t;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic              ui_clk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              init_calib_complete = 1'b0;
    logic              r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
    logic [DATA_W-1:0] r0_wdata = '0, r1_wdata = '0;
    logic              r0_ack, r1_ack, r0_rd_valid, r1_rd_valid;
    logic [DATA_W-1:0] r0_rd_data, r1_rd_data;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en, app_wdf_wren, app_wdf_end;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_rdy = 1'b1, app_wdf_rdy = 1'b1;
    logic [DATA_W-1:0] app_rd_data = '0;
    logic              app_rd_data_valid = 1'b0;
    logic              err_unexpected_rd;

    mig_app_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
        .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rd_data(r0_rd_data), .r0_rd_valid(r0_rd_valid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rd_data(r1_rd_data), .r1_rd_valid(r1_rd_valid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .err_unexpected_rd(err_unexpected_rd)
    );

    always #5 ui_clk = ~ui_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level, queue of tags) ----------------
    bit                m_live = 1'b0;
    bit                m_cal = 1'b0;
    int                m_busy = -1;
    int                m_ptr = 0;
    int                m_tags[$];
    int                m_out, m_pick, m_id;
    bit                m_el0, m_el1;
    int                cyc = 0;

    logic              e_en = 1'b0, e_wren = 1'b0, e_err = 1'b0;
    logic [2:0]        e_cmd = '0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_wdata = '0;
    logic              e_ack [2];
    logic              e_rdv [2];
    logic [DATA_W-1:0] e_rdd [2];

    always @(posedge ui_clk) begin
        cyc++;
        m_out = m_tags.size();
        for (int i = 0; i < 2; i++) begin
            e_ack[i] = 1'b0;
            e_rdv[i] = 1'b0;
        end
        if (!sys_rst) begin
            e_en = 0; e_wren = 0; e_err = 0; e_cmd = '0; e_addr = '0; e_wdata = '0;
            e_rdd[0] = '0; e_rdd[1] = '0;
            m_cal = 0; m_busy = -1; m_ptr = 0;
            m_tags.delete();
        end else begin
            if (app_rd_data_valid) begin
                if (m_tags.size() > 0) begin
                    m_id = m_tags.pop_front();
                    e_rdv[m_id] = 1'b1;
                    e_rdd[m_id] = app_rd_data;
                end else begin
                    e_err = 1'b1;
                end
            end
            if (m_busy >= 0) begin
                if (app_rdy && (e_cmd == 3'b001 || app_wdf_rdy)) begin
                    e_en = 0;
                    e_wren = 0;
                    e_ack[m_busy] = 1'b1;
                    if (e_cmd == 3'b001) m_tags.push_back(m_busy);
                    m_busy = -1;
                end
            end else if (!m_cal) begin
                m_cal = init_calib_complete;
            end else if (!init_calib_complete) begin
                m_cal = 0;
            end else begin
                m_el0 = r0_req && (r0_we || m_out < TAG_DEPTH);
                m_el1 = r1_req && (r1_we || m_out < TAG_DEPTH);
                if (m_el0 || m_el1) begin
                    m_pick = (m_el0 && m_el1) ? m_ptr : (m_el1 ? 1 : 0);
                    m_ptr  = 1 - m_pick;
                    m_busy = m_pick;
                    e_en   = 1'b1;
                    e_addr  = (m_pick == 1) ? r1_addr : r0_addr;
                    e_wdata = (m_pick == 1) ? r1_wdata : r0_wdata;
                    e_wren  = (m_pick == 1) ? r1_we : r0_we;
                    e_cmd   = e_wren ? 3'b000 : 3'b001;
                end
            end
        end
        m_live = 1'b1;
    end

    always @(negedge ui_clk) begin
        if (m_live) begin
            check("app_en",       DATA_W'(app_en),       DATA_W'(e_en));
            check("app_cmd",      DATA_W'(app_cmd),      DATA_W'(e_cmd));
            check("app_addr",     DATA_W'(app_addr),     DATA_W'(e_addr));
            check("app_wdf_data", app_wdf_data,          e_wdata);
            check("app_wdf_wren", DATA_W'(app_wdf_wren), DATA_W'(e_wren));
            check("app_wdf_end",  DATA_W'(app_wdf_end),  DATA_W'(e_wren));
            check("r0_ack",       DATA_W'(r0_ack),       DATA_W'(e_ack[0]));
            check("r1_ack",       DATA_W'(r1_ack),       DATA_W'(e_ack[1]));
            check("r0_rd_valid",  DATA_W'(r0_rd_valid),  DATA_W'(e_rdv[0]));
            check("r1_rd_valid",  DATA_W'(r1_rd_valid),  DATA_W'(e_rdv[1]));
            check("r0_rd_data",   r0_rd_data,            e_rdd[0]);
            check("r1_rd_data",   r1_rd_data,            e_rdd[1]);
            check("err",          DATA_W'(err_unexpected_rd), DATA_W'(e_err));
        end
    end

    // ---------------- requester drivers and stimulus helpers ----------------
    cmd_t q0[$], q1[$];
    ack_t ack_log[$];
    rd_t  rd_log[$];
    bit   rand_mig = 1'b0;

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = ADDR_W'($urandom);
        c.wdata = rand_data();
        return c;
    endfunction

    task automatic step(input bit v = 1'b0, input logic [DATA_W-1:0] d = '0);
        @(negedge ui_clk);
        if (r0_rd_valid) rd_log.push_back('{0, r0_rd_data});
        if (r1_rd_valid) rd_log.push_back('{1, r1_rd_data});
        if (r0_req && r0_ack && q0.size() > 0) begin
            ack_log.push_back('{0, q0[0].we, q0[0].addr, cyc});
            void'(q0.pop_front());
        end
        if (r1_req && r1_ack && q1.size() > 0) begin
            ack_log.push_back('{1, q1[0].we, q1[0].addr, cyc});
            void'(q1.pop_front());
        end
        if (q0.size() > 0) begin
            r0_req = 1'b1; r0_we = q0[0].we; r0_addr = q0[0].addr; r0_wdata = q0[0].wdata;
        end else begin
            r0_req = 1'b0;
        end
        if (q1.size() > 0) begin
            r1_req = 1'b1; r1_we = q1[0].we; r1_addr = q1[0].addr; r1_wdata = q1[0].wdata;
        end else begin
            r1_req = 1'b0;
        end
        app_rd_data_valid = v;
        app_rd_data       = d;
        if (rand_mig) begin
            app_rdy     = ($urandom_range(0, 3) != 0);
            app_wdf_rdy = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        for (int i = 0; i < budget && ack_log.size() < n; i++) step();
        check(name, DATA_W'(ack_log.size() >= n), DATA_W'(1));
    endtask

    task automatic wait_en(input int budget, input string name);
        for (int i = 0; i < budget && !app_en; i++) step();
        check(name, DATA_W'(app_en), DATA_W'(1));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 600 && (q0.size() > 0 || q1.size() > 0 || m_tags.size() > 0); i++)
            step(m_tags.size() > 0, rand_data());
        step();
        step();
        check(name, DATA_W'(q0.size() + q1.size() + m_tags.size()), DATA_W'(0));
    endtask

    task automatic pulse_reset();
        sys_rst = 1'b0;
        q0.delete();
        q1.delete();
        step();
        step();
        sys_rst = 1'b1;
        step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int                base;
        bit                flag;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] exp_a [6];
        bit                exp_we [6];

        repeat (3) step();
        sys_rst = 1'b1;

        // Calibration gate: a write waits while init_calib_complete is low
        d = rand_data();
        q0.push_back('{1'b1, ADDR_W'(0), d});
        flag = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (app_en) flag = 1'b0;
        end
        check("calib_gate_en_low", DATA_W'(flag), DATA_W'(1));
        init_calib_complete = 1'b1;
        wait_en(10, "calib_first_issue");
        check("calib_cmd",  DATA_W'(app_cmd), DATA_W'(3'b000));
        check("calib_addr", DATA_W'(app_addr), DATA_W'(0));
        check("calib_wren", DATA_W'(app_wdf_wren), DATA_W'(1));
        check("calib_end",  DATA_W'(app_wdf_end), DATA_W'(1));
        check("calib_data", app_wdf_data, d);
        repeat (10) step();
        check("calib_one_ack", DATA_W'(ack_log.size()), DATA_W'(1));

        // Round-robin from a fresh pointer
        pulse_reset();
        base = ack_log.size();
        for (int k = 0; k < 3; k++) begin
            q0.push_back('{1'b1, ADDR_W'(8 * k), rand_data()});
            q1.push_back('{1'b0, ADDR_W'('h100 + 8 * k), rand_data()});
        end
        exp_a  = '{ADDR_W'(0), ADDR_W'('h100), ADDR_W'(8), ADDR_W'('h108),
                   ADDR_W'(16), ADDR_W'('h110)};
        exp_we = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        wait_acks(base + 6, 60, "rr_all_acked");
        if (ack_log.size() >= base + 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("rr_addr%0d", k), DATA_W'(ack_log[base+k].addr), DATA_W'(exp_a[k]));
                check($sformatf("rr_we%0d", k), DATA_W'(ack_log[base+k].we), DATA_W'(exp_we[k]));
                if (k > 0)
                    check($sformatf("rr_spacing%0d", k),
                          DATA_W'(ack_log[base+k].cyc - ack_log[base+k-1].cyc), DATA_W'(2));
            end
        end
        drain("rr_drain");

        // Write-data backpressure
        base = ack_log.size();
        app_wdf_rdy = 1'b0;
        q0.push_back('{1'b1, ADDR_W'('h40), rand_data()});
        wait_en(10, "bp_issue");
        a = app_addr;
        d = app_wdf_data;
        flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!app_en || !app_wdf_wren || app_addr !== a || app_wdf_data !== d || r0_ack)
                flag = 1'b0;
        end
        check("bp_stable", DATA_W'(flag), DATA_W'(1));
        check("bp_no_ack", DATA_W'(ack_log.size()), DATA_W'(base));
        app_wdf_rdy = 1'b1;
        wait_acks(base + 1, 10, "bp_ack_after_rdy");

        // Read routing
        base = ack_log.size();
        q1.push_back('{1'b0, ADDR_W'('h100), rand_data()});
        wait_acks(base + 1, 20, "route_r1_issue");
        q0.push_back('{1'b0, ADDR_W'('h200), rand_data()});
        wait_acks(base + 2, 20, "route_r0_issue");
        step();
        rd_log.delete();
        step(1'b1, DATA_W'('hAA));
        step(1'b1, DATA_W'('hBB));
        check("route_first_count", DATA_W'(rd_log.size()), DATA_W'(1));
        if (rd_log.size() >= 1) begin
            check("route_first_id",   DATA_W'(rd_log[0].id), DATA_W'(1));
            check("route_first_data", rd_log[0].data, DATA_W'('hAA));
        end
        step();
        check("route_second_count", DATA_W'(rd_log.size()), DATA_W'(2));
        if (rd_log.size() >= 2) begin
            check("route_second_id",   DATA_W'(rd_log[1].id), DATA_W'(0));
            check("route_second_data", rd_log[1].data, DATA_W'('hBB));
        end

        // Tag FIFO full
        base = ack_log.size();
        for (int k = 0; k < TAG_DEPTH; k++)
            q1.push_back('{1'b0, ADDR_W'('h1000 + 8 * k), rand_data()});
        wait_acks(base + TAG_DEPTH, 100, "full_fill");
        q1.push_back('{1'b0, ADDR_W'('h2000), rand_data()});
        q0.push_back('{1'b1, ADDR_W'('h3000), rand_data()});
        repeat (20) step();
        check("full_count_after_wait", DATA_W'(ack_log.size()), DATA_W'(base + TAG_DEPTH + 1));
        if (ack_log.size() > 0)
            check("full_write_passes", DATA_W'(ack_log[ack_log.size()-1].addr), DATA_W'('h3000));
        step(1'b1, rand_data());
        step();
        step(1'b1, rand_data());
        step();
        check("full_read17_issued", DATA_W'(ack_log.size()), DATA_W'(base + TAG_DEPTH + 2));
        q1.push_back('{1'b0, ADDR_W'('h2008), rand_data()});
        q1.push_back('{1'b0, ADDR_W'('h2010), rand_data()});
        repeat (20) step();
        check("full_read18_only", DATA_W'(ack_log.size()), DATA_W'(base + TAG_DEPTH + 3));
        drain("full_drain");

        // Randomized traffic with backpressure and calibration drops
        begin
            int cal_hold;
            cal_hold = 0;
            rand_mig = 1'b1;
            for (int i = 0; i < 2000; i++) begin
                if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_cmd());
                if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_cmd());
                if (cal_hold > 0) cal_hold--;
                else if ($urandom_range(0, 299) == 0) cal_hold = 6;
                init_calib_complete = (cal_hold == 0);
                step(m_tags.size() > 0 && $urandom_range(0, 2) == 0, rand_data());
            end
            rand_mig = 1'b0;
            app_rdy = 1'b1;
            app_wdf_rdy = 1'b1;
            init_calib_complete = 1'b1;
            drain("random_drain");
        end

        // Reset during ISSUE, then an unexpected return
        base = ack_log.size();
        app_rdy = 1'b0;
        q0.push_back('{1'b1, ADDR_W'('h80), rand_data()});
        wait_en(10, "rst_issue");
        sys_rst = 1'b0;
        step();
        check("rst_en_dropped", DATA_W'(app_en), DATA_W'(0));
        check("rst_no_ack", DATA_W'(r0_ack), DATA_W'(0));
        sys_rst = 1'b1;
        q0.delete();
        app_rdy = 1'b1;
        repeat (5) step();
        check("rst_abandoned", DATA_W'(ack_log.size()), DATA_W'(base));
        check("rst_err_clear", DATA_W'(err_unexpected_rd), DATA_W'(0));
        step(1'b1, DATA_W'('hDEAD));
        step();
        check("unexp_no_valid", DATA_W'(r0_rd_valid | r1_rd_valid), DATA_W'(0));
        check("unexp_err_set", DATA_W'(err_unexpected_rd), DATA_W'(1));
        repeat (3) step();
        check("unexp_err_sticky", DATA_W'(err_unexpected_rd), DATA_W'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
